// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - state type and control bundle shared by hazard_ctrl and its bench
`ifndef HAZARD_DEFS_SV
`include "hazard_defs.sv"
`endif
package hazard_ctrl_pkg;

   localparam int STATE_W = `HZ_STATE_WIDTH;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = `HZ_ST_IDLE,
      ST_RUN   = `HZ_ST_RUN,
      ST_WAIT  = `HZ_ST_WAIT,
      ST_FLUSH = `HZ_ST_FLUSH,
      ST_HALT  = `HZ_ST_HALT
   } hz_state_t;

   typedef struct packed {
      logic fetch_ce;
      logic fetch_stall;
      logic fetch_flush;
      logic decode_stall;
      logic decode_flush;
      logic ex_bubble;
      logic halted;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard sources in, fetch/decode/EX controls out
interface hazard_ctrl_if #(
   parameter int AWIDTH = 5
);
   logic              hc_i_en;
   logic [AWIDTH-1:0] hc_i_rs1_addr;
   logic [AWIDTH-1:0] hc_i_rs2_addr;
   logic              hc_i_rs1_used;
   logic              hc_i_rs2_used;
   logic [AWIDTH-1:0] hc_i_ex_rd_addr;
   logic              hc_i_ex_load;
   logic              hc_i_ex_valid;
   logic              hc_i_branch_taken;
   logic              hc_i_imem_ready;
   logic              hc_i_halt;
   logic              hc_o_fetch_ce;
   logic              hc_o_fetch_stall;
   logic              hc_o_fetch_flush;
   logic              hc_o_decode_stall;
   logic              hc_o_decode_flush;
   logic              hc_o_ex_bubble;
   logic [2:0]        hc_o_state;
   logic              hc_o_halted;

   modport master (
      output hc_i_en, hc_i_rs1_addr, hc_i_rs2_addr, hc_i_rs1_used, hc_i_rs2_used,
             hc_i_ex_rd_addr, hc_i_ex_load, hc_i_ex_valid, hc_i_branch_taken,
             hc_i_imem_ready, hc_i_halt,
      input  hc_o_fetch_ce, hc_o_fetch_stall, hc_o_fetch_flush, hc_o_decode_stall,
             hc_o_decode_flush, hc_o_ex_bubble, hc_o_state, hc_o_halted
   );

   modport slave (
      input  hc_i_en, hc_i_rs1_addr, hc_i_rs2_addr, hc_i_rs1_used, hc_i_rs2_used,
             hc_i_ex_rd_addr, hc_i_ex_load, hc_i_ex_valid, hc_i_branch_taken,
             hc_i_imem_ready, hc_i_halt,
      output hc_o_fetch_ce, hc_o_fetch_stall, hc_o_fetch_flush, hc_o_decode_stall,
             hc_o_decode_flush, hc_o_ex_bubble, hc_o_state, hc_o_halted
   );
endinterface

// File: rtl/hazard_defs.sv
// rtl/hazard_defs.sv - shared state codes for the pipeline sequencing controllers
`ifndef HAZARD_DEFS_SV
`define HAZARD_DEFS_SV
`define HZ_STATE_WIDTH 3
`define HZ_ST_IDLE  3'd0
`define HZ_ST_RUN   3'd1
`define HZ_ST_WAIT  3'd2
`define HZ_ST_FLUSH 3'd3
`define HZ_ST_HALT  3'd4
`endif

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator of decode sources against the EX load
module hazard_detect #(
   parameter int AWIDTH = 5
) (
   input  logic [AWIDTH-1:0] i_rs1_addr,
   input  logic [AWIDTH-1:0] i_rs2_addr,
   input  logic              i_rs1_used,
   input  logic              i_rs2_used,
   input  logic [AWIDTH-1:0] i_ex_rd_addr,
   input  logic              i_ex_load,
   input  logic              i_ex_valid,
   output logic              o_load_use
);
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_rd_live;

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign w_rd_live  = i_ex_valid && i_ex_load && (i_ex_rd_addr != '0);
   assign w_rs1_hit  = i_rs1_used && (i_rs1_addr == i_ex_rd_addr);
   assign w_rs2_hit  = i_rs2_used && (i_rs2_addr == i_ex_rd_addr);
   assign o_load_use = w_rd_live && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - fetch/decode stall, flush and ce sequencer; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int AWIDTH       = 5,
   parameter int FLUSH_CYCLES = 2
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_WIDTH    = 16
`endif
) (
   input  logic c_clk,
   input  logic c_rst,
   hazard_ctrl_if.slave hc
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] hc_o_stall_cnt,
   output logic [CNT_WIDTH-1:0] hc_o_flush_cnt
`endif
);
   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

   hz_state_t       r_state;
   logic [FC_W-1:0] r_flush_cnt;
   hz_state_t       w_next;
   hz_ctrl_t        w_ctrl;
   logic            w_load_use;
   logic            w_br_accept;

   hazard_detect #(.AWIDTH(AWIDTH)) u_detect (
      .i_rs1_addr   (hc.hc_i_rs1_addr),
      .i_rs2_addr   (hc.hc_i_rs2_addr),
      .i_rs1_used   (hc.hc_i_rs1_used),
      .i_rs2_used   (hc.hc_i_rs2_used),
      .i_ex_rd_addr (hc.hc_i_ex_rd_addr),
      .i_ex_load    (hc.hc_i_ex_load),
      .i_ex_valid   (hc.hc_i_ex_valid),
      .o_load_use   (w_load_use)
   );

   // Mealy decode: a hazard seen this cycle stalls this cycle
   always_comb begin
      w_ctrl      = CTRL_NONE;
      w_next      = r_state;
      w_br_accept = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (hc.hc_i_en) w_next = ST_RUN;
         end
         ST_RUN: begin
            w_ctrl.fetch_ce = 1'b1;
            if (hc.hc_i_branch_taken) begin
               w_ctrl.fetch_flush  = 1'b1;
               w_ctrl.decode_flush = 1'b1;
               w_br_accept         = 1'b1;
               w_next              = ST_FLUSH;
            end else if (hc.hc_i_halt) begin
               w_ctrl.fetch_stall  = 1'b1;
               w_ctrl.decode_stall = 1'b1;
               w_next              = ST_HALT;
            end else if (w_load_use) begin
               w_ctrl.fetch_stall  = 1'b1;
               w_ctrl.decode_stall = 1'b1;
               w_ctrl.ex_bubble    = 1'b1;
            end else if (!hc.hc_i_imem_ready) begin
               w_ctrl.fetch_stall  = 1'b1;
               w_next              = ST_WAIT;
            end else if (!hc.hc_i_en) begin
               w_next              = ST_IDLE;
            end
         end
         ST_WAIT: begin
            w_ctrl.fetch_ce = 1'b1;
            if (hc.hc_i_branch_taken) begin
               w_ctrl.fetch_flush  = 1'b1;
               w_ctrl.decode_flush = 1'b1;
               w_br_accept         = 1'b1;
               w_next              = ST_FLUSH;
            end else begin
               w_ctrl.fetch_stall  = 1'b1;
               w_ctrl.decode_flush = 1'b1;
               if (hc.hc_i_imem_ready) w_next = ST_RUN;
            end
         end
         ST_FLUSH: begin
            w_ctrl.fetch_ce     = 1'b1;
            w_ctrl.fetch_flush  = 1'b1;
            w_ctrl.decode_flush = 1'b1;
            if (r_flush_cnt == '0) w_next = hc.hc_i_en ? ST_RUN : ST_IDLE;
         end
         ST_HALT: begin
            w_ctrl.fetch_stall  = 1'b1;
            w_ctrl.decode_stall = 1'b1;
            w_ctrl.halted       = 1'b1;
         end
         default: w_next = ST_IDLE;
      endcase
      if (c_rst) w_ctrl = CTRL_NONE;
   end

   always_ff @(posedge c_clk) begin
      if (c_rst) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_br_accept) begin
            r_flush_cnt <= FC_LOAD;
         end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
            r_flush_cnt <= r_flush_cnt - FC_W'(1);
         end
      end
   end

   assign hc.hc_o_fetch_ce     = w_ctrl.fetch_ce;
   assign hc.hc_o_fetch_stall  = w_ctrl.fetch_stall;
   assign hc.hc_o_fetch_flush  = w_ctrl.fetch_flush;
   assign hc.hc_o_decode_stall = w_ctrl.decode_stall;
   assign hc.hc_o_decode_flush = w_ctrl.decode_flush;
   assign hc.hc_o_ex_bubble    = w_ctrl.ex_bubble;
   assign hc.hc_o_halted       = w_ctrl.halted;
   assign hc.hc_o_state        = r_state;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_evt_cnt;

   // A bubble is only ever issued for a load-use stall, so it doubles as the stall event
   always_ff @(posedge c_clk) begin
      if (c_rst) begin
         r_stall_cnt     <= '0;
         r_flush_evt_cnt <= '0;
      end else begin
         if (w_ctrl.ex_bubble && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         end
         if (w_br_accept && (r_flush_evt_cnt != '1)) begin
            r_flush_evt_cnt <= r_flush_evt_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign hc_o_stall_cnt = r_stall_cnt;
   assign hc_o_flush_cnt = r_flush_evt_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl; HAZARD_PERF_CNT_EN also checks the counters
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic c_clk = 1'b0;
   logic c_rst = 1'b1;
   always #5 c_clk = ~c_clk;

   hazard_ctrl_if #(.AWIDTH(5)) hc ();

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   hazard_ctrl dut (
      .c_clk (c_clk),
      .c_rst (c_rst),
      .hc    (hc)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .hc_o_stall_cnt (stall_cnt),
      .hc_o_flush_cnt (flush_cnt)
`endif
   );

   // {state[2:0], halted, bubble, dflush, dstall, fflush, fstall, ce}
   localparam logic [9:0] E_IDLE     = 10'b000_0000000;
   localparam logic [9:0] E_RUN      = 10'b001_0000001;
   localparam logic [9:0] E_LU       = 10'b001_0101011;
   localparam logic [9:0] E_BR_RUN   = 10'b001_0010101;
   localparam logic [9:0] E_FLUSH    = 10'b011_0010101;
   localparam logic [9:0] E_RUN_MISS = 10'b001_0000011;
   localparam logic [9:0] E_WAIT     = 10'b010_0010011;
   localparam logic [9:0] E_BR_WAIT  = 10'b010_0010101;
   localparam logic [9:0] E_HALT_REQ = 10'b001_0001011;
   localparam logic [9:0] E_HALT     = 10'b100_1001010;
   localparam logic [9:0] E_RST_FL   = 10'b011_0000000;
   localparam logic [9:0] E_RST_HALT = 10'b100_0000000;

   typedef struct packed {
      logic       rst, en, rdy, br, hlt, vld, ld, u1, u2;
      logic [4:0] rd, rs1, rs2;
   } stim_t;

   int total = 0;
   int bad   = 0;
   logic [9:0] sb[$];

   function automatic stim_t mk(input logic en, rdy, br, hlt, rst);
      stim_t s;
      s     = '0;
      s.en  = en;
      s.rdy = rdy;
      s.br  = br;
      s.hlt = hlt;
      s.rst = rst;
      return s;
   endfunction

   function automatic stim_t mklu(input logic [4:0] rd, rs1, rs2, input logic u1, u2, ld, vld);
      stim_t s;
      s     = mk(1, 1, 0, 0, 0);
      s.rd  = rd;
      s.rs1 = rs1;
      s.rs2 = rs2;
      s.u1  = u1;
      s.u2  = u2;
      s.ld  = ld;
      s.vld = vld;
      return s;
   endfunction

   function automatic logic [9:0] obs();
      return {hc.hc_o_state, hc.hc_o_halted, hc.hc_o_ex_bubble, hc.hc_o_decode_flush,
              hc.hc_o_decode_stall, hc.hc_o_fetch_flush, hc.hc_o_fetch_stall, hc.hc_o_fetch_ce};
   endfunction

   task automatic apply(input stim_t s);
      c_rst                = s.rst;
      hc.hc_i_en           = s.en;
      hc.hc_i_imem_ready   = s.rdy;
      hc.hc_i_branch_taken = s.br;
      hc.hc_i_halt         = s.hlt;
      hc.hc_i_ex_valid     = s.vld;
      hc.hc_i_ex_load      = s.ld;
      hc.hc_i_rs1_used     = s.u1;
      hc.hc_i_rs2_used     = s.u2;
      hc.hc_i_ex_rd_addr   = s.rd;
      hc.hc_i_rs1_addr     = s.rs1;
      hc.hc_i_rs2_addr     = s.rs2;
   endtask

   task automatic test_reset();
      stim_t s[$];
      logic [9:0] e;
      apply(mk(1, 1, 0, 0, 1));
      @(posedge c_clk); #1;
      s.push_back(mk(1, 1, 0, 0, 1)); sb.push_back(E_IDLE);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_IDLE);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         @(negedge c_clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL reset[%0d] got=%b want=%b", i, obs(), e);
         end
         @(posedge c_clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t s[$];
      logic [9:0] e;
      s.push_back(mklu(5, 0, 5, 0, 1, 1, 1)); sb.push_back(E_LU);
      s.push_back(mk(1, 1, 0, 0, 0));         sb.push_back(E_RUN);
      s.push_back(mklu(0, 0, 0, 0, 1, 1, 1)); sb.push_back(E_RUN);
      s.push_back(mklu(7, 7, 2, 1, 0, 1, 1)); sb.push_back(E_LU);
      s.push_back(mklu(7, 7, 7, 0, 0, 1, 1)); sb.push_back(E_RUN);
      s.push_back(mklu(9, 0, 9, 0, 1, 0, 1)); sb.push_back(E_RUN);
      s.push_back(mklu(9, 9, 0, 1, 0, 1, 0)); sb.push_back(E_RUN);
      s.push_back(mklu(31, 4, 31, 1, 1, 1, 1)); sb.push_back(E_LU);
      s.push_back(mk(1, 1, 0, 0, 0));         sb.push_back(E_RUN);
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         @(negedge c_clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL load_use[%0d] got=%b want=%b", i, obs(), e);
         end
         @(posedge c_clk); #1;
      end
   endtask

   task automatic test_branch();
      stim_t s[$];
      stim_t t;
      logic [9:0] e;
      s.push_back(mk(1, 1, 1, 0, 0)); sb.push_back(E_BR_RUN);
      s.push_back(mk(1, 1, 1, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      t = mklu(3, 3, 0, 1, 0, 1, 1);
      t.br = 1'b1;
      s.push_back(t);                 sb.push_back(E_BR_RUN);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(1, 1, 1, 1, 0)); sb.push_back(E_BR_RUN);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         @(negedge c_clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL branch[%0d] got=%b want=%b", i, obs(), e);
         end
         @(posedge c_clk); #1;
      end
   endtask

   task automatic test_wait();
      stim_t s[$];
      logic [9:0] e;
      s.push_back(mk(1, 0, 0, 0, 0)); sb.push_back(E_RUN_MISS);
      s.push_back(mk(1, 0, 0, 0, 0)); sb.push_back(E_WAIT);
      s.push_back(mk(1, 0, 0, 0, 0)); sb.push_back(E_WAIT);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_WAIT);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      s.push_back(mk(1, 0, 0, 0, 0)); sb.push_back(E_RUN_MISS);
      s.push_back(mk(1, 0, 1, 0, 0)); sb.push_back(E_BR_WAIT);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         @(negedge c_clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL wait[%0d] got=%b want=%b", i, obs(), e);
         end
         @(posedge c_clk); #1;
      end
   endtask

   task automatic test_enable();
      stim_t s[$];
      logic [9:0] e;
      s.push_back(mk(0, 1, 0, 0, 0)); sb.push_back(E_RUN);
      s.push_back(mk(0, 1, 0, 0, 0)); sb.push_back(E_IDLE);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_IDLE);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      s.push_back(mk(1, 1, 1, 0, 0)); sb.push_back(E_BR_RUN);
      s.push_back(mk(0, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(0, 1, 0, 0, 0)); sb.push_back(E_FLUSH);
      s.push_back(mk(0, 1, 0, 0, 0)); sb.push_back(E_IDLE);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_IDLE);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         @(negedge c_clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL enable[%0d] got=%b want=%b", i, obs(), e);
         end
         @(posedge c_clk); #1;
      end
   endtask

   task automatic test_reset_mid_flush();
      stim_t s[$];
      logic [9:0] e;
      s.push_back(mk(1, 1, 1, 0, 0)); sb.push_back(E_BR_RUN);
      s.push_back(mk(1, 1, 0, 0, 1)); sb.push_back(E_RST_FL);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_IDLE);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         @(negedge c_clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL reset_mid[%0d] got=%b want=%b", i, obs(), e);
         end
         @(posedge c_clk); #1;
      end
   endtask

   task automatic test_halt();
      stim_t s[$];
      logic [9:0] e;
      s.push_back(mk(1, 1, 0, 1, 0)); sb.push_back(E_HALT_REQ);
      for (int k = 0; k < 10; k++) begin
         s.push_back(mk((k % 3) != 0, (k % 2) == 0, k == 4, 0, 0));
         sb.push_back(E_HALT);
      end
      s.push_back(mk(1, 1, 0, 0, 1)); sb.push_back(E_RST_HALT);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_IDLE);
      s.push_back(mk(1, 1, 0, 0, 0)); sb.push_back(E_RUN);
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         @(negedge c_clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL halt[%0d] got=%b want=%b", i, obs(), e);
         end
         @(posedge c_clk); #1;
      end
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf_cnt();
      stim_t s[$];
      int exp_st = 0;
      int exp_fl = 0;
      apply(mk(1, 1, 0, 0, 1));
      @(posedge c_clk); #1;
      apply(mk(1, 1, 0, 0, 0));
      @(negedge c_clk);
      total++;
      if (stall_cnt !== 16'd0) begin bad++; $display("FAIL perf_stall_rst got=%0d want=0", stall_cnt); end
      total++;
      if (flush_cnt !== 16'd0) begin bad++; $display("FAIL perf_flush_rst got=%0d want=0", flush_cnt); end
      @(posedge c_clk); #1;
      s.push_back(mklu(5, 5, 0, 1, 0, 1, 1)); exp_st++;
      s.push_back(mklu(6, 0, 6, 0, 1, 1, 1)); exp_st++;
      s.push_back(mk(1, 1, 0, 0, 0));
      s.push_back(mklu(8, 8, 8, 1, 1, 1, 1)); exp_st++;
      s.push_back(mk(1, 1, 1, 0, 0));         exp_fl++;
      s.push_back(mk(1, 1, 1, 0, 0));
      s.push_back(mk(1, 1, 0, 0, 0));
      s.push_back(mk(1, 1, 1, 0, 0));         exp_fl++;
      s.push_back(mk(1, 1, 0, 0, 0));
      s.push_back(mk(1, 1, 0, 0, 0));
      s.push_back(mk(1, 1, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         @(posedge c_clk); #1;
      end
      @(negedge c_clk);
      total++;
      if (stall_cnt !== 16'(exp_st)) begin bad++; $display("FAIL perf_stall got=%0d want=%0d", stall_cnt, exp_st); end
      total++;
      if (flush_cnt !== 16'(exp_fl)) begin bad++; $display("FAIL perf_flush got=%0d want=%0d", flush_cnt, exp_fl); end
      @(posedge c_clk); #1;
      apply(mk(1, 1, 0, 0, 1));
      @(posedge c_clk); #1;
      apply(mk(1, 1, 0, 0, 0));
      @(negedge c_clk);
      total++;
      if (stall_cnt !== 16'd0) begin bad++; $display("FAIL perf_stall_clr got=%0d want=0", stall_cnt); end
      total++;
      if (flush_cnt !== 16'd0) begin bad++; $display("FAIL perf_flush_clr got=%0d want=0", flush_cnt); end
      @(posedge c_clk); #1;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      apply(mk(1, 1, 0, 0, 1));
      test_reset();
      test_load_use();
      test_branch();
      test_wait();
      test_enable();
      test_reset_mid_flush();
      test_halt();
`ifdef HAZARD_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
